// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;

   localparam logic [31:0] DMEM_BASE_DEF = 32'h0000_0800;
   localparam logic [31:0] MMIO_BASE_DEF = 32'h0000_0C00;
   localparam int          MMIO_WORDS    = 5;

   localparam logic [31:0] OFF_LED      = 32'h00;
   localparam logic [31:0] OFF_SEVENSEG = 32'h04;
   localparam logic [31:0] OFF_SWITCH   = 32'h08;
   localparam logic [31:0] OFF_CYCLE    = 32'h0C;
   localparam logic [31:0] OFF_STATUS   = 32'h10;

   typedef enum logic [1:0] {
      REGION_NONE,
      REGION_RAM,
      REGION_MMIO
   } region_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, async active-high reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory port target: word RAM plus a five-word MMIO bank.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE counter.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
   parameter int          DMEM_DEPTH = 128,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
   parameter int          SW_WIDTH   = 16,
   parameter int          LED_WIDTH  = 16
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 MemWrite,
   input  logic [31:0]          Addr,
   input  logic [31:0]          WriteData,
   output logic [31:0]          ReadData,
   input  logic [SW_WIDTH-1:0]  Switches,
   output logic [LED_WIDTH-1:0] LED,
   output logic [31:0]          SevenSegValue,
   output logic                 AccessErr
);

   localparam int          AW       = $clog2(DMEM_DEPTH);
   localparam logic [31:0] DMEM_END = DMEM_BASE + 32'(4 * DMEM_DEPTH);
   localparam logic [31:0] MMIO_END = MMIO_BASE + 32'(4 * MMIO_WORDS);

   logic [31:0]          mem [DMEM_DEPTH];
   logic [31:0]          ram_off;
   logic [31:0]          mmio_off;
   logic [AW-1:0]        ram_idx;
   logic                 aligned;
   region_t              region;
   logic [SW_WIDTH-1:0]  sw_sync;
   logic                 unused_ram_off;

   logic wr_ram;
   logic wr_led;
   logic wr_seg;
   logic wr_stat;
   logic wr_bad;
`ifdef DMEM_CYCLE_COUNTER_EN
   logic        wr_cyc;
   logic [31:0] cycle;
`endif

   assign ram_off        = Addr - DMEM_BASE;
   assign mmio_off       = Addr - MMIO_BASE;
   assign ram_idx        = ram_off[AW+1:2];
   assign unused_ram_off = ^{ram_off[31:AW+2], ram_off[1:0]};
   assign aligned        = (Addr[1:0] == 2'b00);

   always_comb begin
      region = REGION_NONE;
      if (Addr >= DMEM_BASE && Addr < DMEM_END)
         region = REGION_RAM;
      else if (Addr >= MMIO_BASE && Addr < MMIO_END)
         region = REGION_MMIO;
   end

   // Only writes are judged; Addr carries every ALU result, so reads never fault.
   always_comb begin
      wr_ram  = 1'b0;
      wr_led  = 1'b0;
      wr_seg  = 1'b0;
      wr_stat = 1'b0;
      wr_bad  = 1'b0;
`ifdef DMEM_CYCLE_COUNTER_EN
      wr_cyc  = 1'b0;
`endif
      if (MemWrite) begin
         if (!aligned) begin
            wr_bad = 1'b1;
         end else begin
            case (region)
               REGION_RAM:  wr_ram = 1'b1;
               REGION_MMIO: begin
                  case (mmio_off)
                     OFF_LED:      wr_led  = 1'b1;
                     OFF_SEVENSEG: wr_seg  = 1'b1;
                     OFF_CYCLE: begin
`ifdef DMEM_CYCLE_COUNTER_EN
                        wr_cyc = 1'b1;
`endif
                     end
                     OFF_STATUS:   wr_stat = 1'b1;
                     default:      wr_bad  = 1'b1;
                  endcase
               end
               default:     wr_bad = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_ram)
         mem[ram_idx] <= WriteData;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         LED           <= '0;
         SevenSegValue <= '0;
         AccessErr     <= 1'b0;
      end else begin
         if (wr_led)
            LED <= WriteData[LED_WIDTH-1:0];
         if (wr_seg)
            SevenSegValue <= WriteData;
         if (wr_bad)
            AccessErr <= 1'b1;
         else if (wr_stat && WriteData[0])
            AccessErr <= 1'b0;
      end
   end

`ifdef DMEM_CYCLE_COUNTER_EN
   // A write wins over the increment on the same edge.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         cycle <= '0;
      else if (wr_cyc)
         cycle <= '0;
      else
         cycle <= cycle + 32'd1;
   end
`endif

   sync_2ff #(
      .WIDTH (SW_WIDTH)
   ) u_sw_sync (
      .clk (CLK),
      .rst (Reset),
      .d   (Switches),
      .q   (sw_sync)
   );

   always_comb begin
      ReadData = 32'h0;
      if (aligned) begin
         case (region)
            REGION_RAM:  ReadData = mem[ram_idx];
            REGION_MMIO: begin
               case (mmio_off)
                  OFF_LED:      ReadData = 32'(LED);
                  OFF_SEVENSEG: ReadData = SevenSegValue;
                  OFF_SWITCH:   ReadData = 32'(sw_sync);
`ifdef DMEM_CYCLE_COUNTER_EN
                  OFF_CYCLE:    ReadData = cycle;
`endif
                  OFF_STATUS:   ReadData = {31'b0, AccessErr};
                  default:      ReadData = 32'h0;
               endcase
            end
            default:     ReadData = 32'h0;
         endcase
      end
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Target end of the processor's data-memory port. The core drives MemWrite, an address (its OpResult) and WriteData, and expects ReadData back in the same cycle. This block answers that port with:
- a word-addressed data RAM;
- a small memory-mapped I/O (MMIO) register bank: LEDs, seven-segment value, synchronised switches, cycle counter, status.
It sits in the top-level wrapper beside the core and the instruction ROM.

Parameters:
DMEM_BASE, 32'h0000_0800, byte base address of the data RAM
DMEM_DEPTH, 128, number of 32-bit words in the RAM (power of two)
MMIO_BASE, 32'h0000_0C00, byte base address of the MMIO bank (5 words)
SW_WIDTH, 16, switch input width
LED_WIDTH, 16, LED output width

Ports:
CLK  in  1  clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-high reset
MemWrite  in  1  write strobe from the core, sampled at the rising edge of CLK
Addr  in  32  byte address from the core (its OpResult); presented every cycle
WriteData  in  32  store data
ReadData  out  32  combinational read data for Addr
Switches  in  SW_WIDTH  asynchronous board switches
LED  out  LED_WIDTH  LED register
SevenSegValue  out  32  seven-segment display register
AccessErr  out  1  sticky bad-write flag

Behaviour:
- Reset (asynchronous, immediate, including mid-operation) clears LED, SevenSegValue, the switch synchroniser, CYCLE and AccessErr to 0. RAM contents are not cleared by reset.
- Address decode uses Addr[31:0]. An access is aligned when Addr[1:0] == 0.
  - RAM hit: DMEM_BASE <= Addr < DMEM_BASE + 4*DMEM_DEPTH.
  - MMIO hit: Addr = MMIO_BASE + offset, with the offsets below.
- MMIO map (offset, access, meaning):
  - 0x00 LED, RW. Writes take WriteData[LED_WIDTH-1:0]. Reads are zero-extended.
  - 0x04 SEVENSEG, RW, full 32 bits.
  - 0x08 SWITCH, RO. Returns the synchronised switches, zero-extended.
  - 0x0C CYCLE, RO. Free-running 32-bit counter. Any write clears it.
  - 0x10 STATUS, RO. bit0 = AccessErr. A write with WriteData[0]=1 clears bit0.
- Reads:
  - Purely combinational, zero cycles of latency, independent of MemWrite.
  - Unmapped or misaligned addresses return 32'h0.
  - Reads never raise an error, because Addr carries OpResult for every instruction, not only loads.
- Writes:
  - Committed at the rising edge when MemWrite=1.
  - A RAM write updates word (Addr - DMEM_BASE) >> 2.
  - A write that is misaligned, unmapped, or to SWITCH is ignored and sets AccessErr.
- Write-then-read: a read in the cycle after a write returns the new value. A read in the same cycle as a write returns the old value.
- Switch synchroniser: two-flop. A switch change becomes visible on ReadData exactly 2 rising edges later.
- CYCLE:
  - Increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
  - A write and an increment in the same cycle resolve to the write: CYCLE is 0 after that edge and reads 1 one cycle later.
- AccessErr: a set and a clear in the same edge cannot both occur (a STATUS write is a legal access). The implementation still gives set priority.
- LED and SevenSegValue drive directly from their registers, with no extra delay.

Optional Feature:
DMEM_CYCLE_COUNTER_EN
- Defined: CYCLE is implemented as specified above.
- Undefined: no counter flops exist. Offset 0x0C reads 0. Writes to 0x0C are silently ignored and do not set AccessErr.

Decomposition:
- Package dmem_pkg holds:
  - the default base addresses and the MMIO offset constants OFF_LED, OFF_SEVENSEG, OFF_SWITCH, OFF_CYCLE, OFF_STATUS;
  - an enumerated region-select type: REGION_NONE, REGION_RAM, REGION_MMIO.
- One sub-module, sync_2ff: parameterised-width two-flop synchroniser with asynchronous active-high reset. It is used for the Switches input.
- RAM and MMIO logic stay in the top module.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x0800. The next cycle, reading 0x0800 returns 32'hDEADBEEF and reading 0x0804 returns the prior content. Writing 0x0800 + 4*127 succeeds. A write to 0x0A00 sets AccessErr=1.
- Write 16'hA5A5 to 0x0C00 -> LED=16'hA5A5 after the edge. Write 32'h12345678 to 0x0C04 -> SevenSegValue=32'h12345678. Assert Reset mid-stream -> LED and SevenSegValue are 0 immediately, before the next edge.
- Switches change to 16'h00FF at edge N -> reading 0x0C08 returns 0 before edge N+2 and 32'h000000FF from edge N+2.
- Write to 0x0C0C at edge N -> reading 0x0C0C returns 1 after edge N+1 and 5 after edge N+5. Preload CYCLE near 32'hFFFF_FFFF via a force -> it wraps to 0. With DMEM_CYCLE_COUNTER_EN undefined -> 0x0C0C always reads 0.
- MemWrite=1 to 0x0802 (misaligned) -> RAM is unchanged and AccessErr=1. Reading 0x0C10 returns 1. Writing 32'h1 to 0x0C10 -> AccessErr=0 the next cycle. MemWrite=0 with Addr=0x0802 or 0xFFFF_FFF0 -> ReadData=0 and AccessErr is unchanged.
